// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin arbiter sharing one combinational 32-bit ALU
//               between NREQ requesters. The granted requester's control code
//               and operands drive the ALU; result and overflow are captured
//               in a one-entry response register with a valid/ready channel.
// Ports       : clk, resetn (async, active-low)
//               req_valid/req_ready/req_ctrl/req_src1/req_src2 : request side
//               req_lock      : hold-grant request (ALU_ARB_LOCK_EN only)
//               alu_ctrl/alu_src1/alu_src2 -> ALU, alu_result/alu_overflow <- ALU
//               rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_overflow : response
// Config      : define ALU_ARB_LOCK_EN to add req_lock and grant locking.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_ctrl,
    input  logic [32*NREQ-1:0]   req_src1,
    input  logic [32*NREQ-1:0]   req_src2,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    output logic [4:0]           alu_ctrl,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    input  logic [31:0]          alu_result,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_overflow
);

    logic [ID_W-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_any;
    logic            lock_hit;
    logic            issue_en;
    logic            issue;
`ifdef ALU_ARB_LOCK_EN
    // rsp_id only names a real "last granted" requester once something issued.
    logic            last_ok;
`endif

    // The register can accept a new result when empty or draining this cycle.
    assign issue_en = ~rsp_valid | rsp_ready;
    assign issue    = issue_en & grant_any;

    // Cyclic priority scan starting at rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant_id  = '0;
        grant_any = 1'b0;
        lock_hit  = 1'b0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
`ifdef ALU_ARB_LOCK_EN
        // A locked, still-valid last winner overrides the round-robin choice.
        for (int i = 0; i < NREQ; i++) begin
            if (last_ok && (int'(rsp_id) == i) && req_lock[i] && req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = rsp_id;
                lock_hit  = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_any && (int'(grant_id) == i);
        end
    end

    assign req_ready = {NREQ{issue_en}} & grant;

    // Operand mux; idle cycles present 0+0 so the ALU stays quiet.
    always_comb begin
        alu_ctrl = '0;
        alu_src1 = '0;
        alu_src2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                alu_ctrl = req_ctrl[5*i +: 5];
                alu_src1 = req_src1[32*i +: 32];
                alu_src2 = req_src2[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_id       <= '0;
            rr_ptr       <= '0;
`ifdef ALU_ARB_LOCK_EN
            last_ok      <= 1'b0;
`endif
        end else if (issue) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_id       <= grant_id;
`ifdef ALU_ARB_LOCK_EN
            last_ok      <= 1'b1;
`endif
            // A locked re-grant keeps the pointer where it was.
            if (!lock_hit) begin
                rr_ptr <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + 1'b1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Self-checking bench for alu_rr_arbiter (NREQ=2). A stand-in
//               ALU model feeds the DUT; a reference arbiter model predicts
//               grants and pushes expected responses into a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    localparam int NREQ = 2;
    localparam int ID_W = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_ctrl;
    logic [32*NREQ-1:0] req_src1;
    logic [32*NREQ-1:0] req_src2;
    logic [NREQ-1:0]   req_lock;
    logic [4:0]        alu_ctrl;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic [31:0]       alu_result;
    logic              alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        ovf;
    } rsp_t;
    rsp_t q[$];

    int   m_ptr;
    bit   m_valid;
    int   m_last;
    bit   m_have_last;
    logic [NREQ-1:0] obs_rdy;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ctrl     (req_ctrl),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
`ifdef ALU_ARB_LOCK_EN
        .req_lock     (req_lock),
`endif
        .alu_ctrl     (alu_ctrl),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow)
    );

    // Stand-in ALU: add/sub, signed-overflow add/sub, unknown codes return 0.
    function automatic logic [32:0] alu_f(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (c)
            5'h00: r = a + b;
            5'h01: r = a - b;
            5'h0C: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            5'h0D: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    assign {alu_overflow, alu_result} = alu_f(alu_ctrl, alu_src1, alu_src2);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b);
        req_ctrl[5*i +: 5]  = c;
        req_src1[32*i +: 32] = a;
        req_src2[32*i +: 32] = b;
    endtask

    // One clock: predict and check at the negedge, advance the model, return at posedge+1.
    task automatic cycle();
        int gid;
        int idx;
        bit issue;
        bit lockhit;
        logic [32:0] r;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        gid = -1;
        lockhit = 1'b0;
        issue = !m_valid || rsp_ready;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (gid < 0 && req_valid[idx]) gid = idx;
        end
`ifdef ALU_ARB_LOCK_EN
        if (m_have_last && req_lock[m_last] && req_valid[m_last]) begin
            gid = m_last;
            lockhit = 1'b1;
        end
`endif
        eg = '0;
        if (issue && gid >= 0) eg[gid] = 1'b1;
        obs_rdy = req_ready;
        check_val("req_ready", 32'(req_ready), 32'(eg));
        if (gid >= 0) begin
            check_val("alu_ctrl", 32'(alu_ctrl), 32'(req_ctrl[5*gid +: 5]));
            check_val("alu_src1", alu_src1, req_src1[32*gid +: 32]);
            check_val("alu_src2", alu_src2, req_src2[32*gid +: 32]);
        end else begin
            check_val("alu_idle", {alu_src1[26:0], alu_ctrl} | alu_src2, 32'h0);
        end
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid && q.size() > 0) begin
            check_val("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check_val("rsp_result", rsp_result, q[0].res);
            check_val("rsp_overflow", 32'(rsp_overflow), 32'(q[0].ovf));
            if (rsp_ready) void'(q.pop_front());
        end
        if (issue && gid >= 0) begin
            r = alu_f(req_ctrl[5*gid +: 5], req_src1[32*gid +: 32], req_src2[32*gid +: 32]);
            q.push_back('{id: gid, res: r[31:0], ovf: r[32]});
            m_valid = 1'b1;
            m_last = gid;
            m_have_last = 1'b1;
            if (!lockhit) m_ptr = (gid + 1) % NREQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check_val("rst_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_id", 32'(rsp_id), 32'h0);
        check_val("rst_result", rsp_result, 32'h0);
        check_val("rst_ovf", 32'(rsp_overflow), 32'h0);
        q.delete();
        m_valid = 1'b0;
        m_ptr = 0;
        m_last = 0;
        m_have_last = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_ord[4];
        req_valid = '0;
        req_ctrl  = '0;
        req_src1  = '0;
        req_src2  = '0;
        req_lock  = '0;
        rsp_ready = 1'b0;
        resetn    = 1'b0;
        #2;
        do_reset();

        // Single requester: 5 + 7
        rsp_ready = 1'b1;
        set_req(0, 5'h00, 32'd5, 32'd7);
        req_valid = 2'b01;
        cycle();
        check_val("t1_ready", 32'(obs_rdy), 32'h1);
        check_val("t1_valid", 32'(rsp_valid), 32'h1);
        check_val("t1_result", rsp_result, 32'd12);
        check_val("t1_id", 32'(rsp_id), 32'h0);
        req_valid = 2'b00;
        cycle();

        // Both valid from reset: strict alternation, one response per cycle
        do_reset();
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 5'h00, 32'(100 + i), 32'd3);
            set_req(1, 5'h0D, 32'(i), 32'h8000_0000);
            cycle();
            check_val("t2_order", 32'(obs_rdy), 32'(exp_ord[i]));
        end

        // Overflow on signed add only for the overflow-flagging code
        req_valid = 2'b10;
        set_req(1, 5'h0C, 32'h7FFF_FFFF, 32'd1);
        cycle();
        check_val("t3_res_ovf", rsp_result, 32'h8000_0000);
        check_val("t3_ovf", 32'(rsp_overflow), 32'h1);
        set_req(1, 5'h00, 32'h7FFF_FFFF, 32'd1);
        cycle();
        check_val("t3_res_add", rsp_result, 32'h8000_0000);
        check_val("t3_no_ovf", 32'(rsp_overflow), 32'h0);

        // Stall for 3 cycles, then release
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        set_req(0, 5'h01, 32'd50, 32'd8);
        set_req(1, 5'h10, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t4_stall_rdy", 32'(obs_rdy), 32'h0);
        end
        rsp_ready = 1'b1;
        cycle();
        check_val("t4_release_rdy", 32'(obs_rdy), 32'h1);
        check_val("t4_new_res", rsp_result, 32'd42);

        // Async reset in the middle of a stall
        rsp_ready = 1'b0;
        cycle();
        cycle();
        #3;
        do_reset();
        rsp_ready = 1'b1;
        cycle();
        check_val("t5_first_grant", 32'(obs_rdy), 32'h1);

        // Lock behaviour (or plain alternation when the lock feature is absent)
        do_reset();
        req_lock  = 2'b01;
        req_valid = 2'b11;
`ifdef ALU_ARB_LOCK_EN
        exp_ord = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_lock = 2'b00;
            set_req(0, 5'h0C, 32'(i * 7), 32'h7FFF_FFF0);
            set_req(1, 5'h00, 32'(i * 9), 32'd11);
            cycle();
            check_val("t6_order", 32'(obs_rdy), 32'(exp_ord[i]));
        end

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_lock  = 2'($urandom_range(0, 3));
            for (int r = 0; r < NREQ; r++) begin
                case ($urandom_range(0, 4))
                    0: set_req(r, 5'h00, $urandom, $urandom);
                    1: set_req(r, 5'h0C, $urandom, $urandom);
                    2: set_req(r, 5'h0D, $urandom, $urandom);
                    3: set_req(r, 5'h01, $urandom, $urandom);
                    default: set_req(r, 5'h1F, $urandom, $urandom);
                endcase
            end
            cycle();
        end

        // Drain
        req_valid = 2'b00;
        req_lock  = 2'b00;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        check_val("drain_empty", 32'(q.size()), 32'h0);
        check_val("drain_valid", 32'(rsp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
